// File: rtl/masked_sbox_feeder_d1.sv
// Flow-control and randomness wrapper around a fixed-latency first-order masked Skinny S-box.
// Credit-based issue, in-flight tracking, output FIFO and a reseedable Galois LFSR for Fresh.
module masked_sbox_feeder_d1 #(
  parameter int          LAT       = 3,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] SEED_INIT = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_s0,
  input  logic [3:0]  in_s1,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  output logic        seed_ack,
  output logic [3:0]  SI_s0,
  output logic [3:0]  SI_s1,
  output logic [3:0]  Fresh,
  input  logic [3:0]  SO_s0,
  input  logic [3:0]  SO_s1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_s0,
  output logic [3:0]  out_s1
);

  localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam int          UW        = $clog2(DEPTH + LAT + 2);
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    RESEED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d, lfsr_adv;
  logic [LAT-1:0]         vld_sr_q, vld_sr_d;
  logic [DEPTH-1:0][7:0]  mem_q, mem_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [UW-1:0]          used;
  logic                   issue, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The entry popped this cycle frees its slot at the same edge, which keeps
  // sustained streaming at one item per cycle without risking FIFO overflow.
  always_comb begin
    used = UW'(count_q);
    for (int i = 0; i < LAT; i++) begin
      used = used + UW'(vld_sr_q[i]);
    end
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    push      = vld_sr_q[LAT-1];
    in_ready  = rst_n && (state_q == RUN) && !seed_valid &&
                ((used - UW'(pop)) < UW'(DEPTH));
    issue     = in_valid && in_ready;
    SI_s0     = issue ? in_s0 : 4'h0;
    SI_s1     = issue ? in_s1 : 4'h0;
    Fresh     = lfsr_q[3:0];
    out_s0    = out_valid ? mem_q[rd_ptr_q][3:0] : 4'h0;
    out_s1    = out_valid ? mem_q[rd_ptr_q][7:4] : 4'h0;
    vld_sr_d  = (vld_sr_q << 1) | LAT'(issue);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {SO_s1, SO_s0};
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lfsr_adv = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    lfsr_d   = lfsr_q;
    seed_ack = 1'b0;
    case (state_q)
      RUN: begin
        lfsr_d = lfsr_adv;
        if (seed_valid) state_d = DRAIN;
      end
      DRAIN: begin
        lfsr_d = lfsr_adv;
        if (vld_sr_q == '0) state_d = RESEED;
      end
      RESEED: begin
        seed_ack = 1'b1;
        lfsr_d   = (seed == 32'h0) ? 32'h1 : seed;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      lfsr_q   <= SEED_INIT;
      vld_sr_q <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      vld_sr_q <= vld_sr_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_masked_sbox_feeder_d1.sv
// Bench for masked_sbox_feeder_d1 with a 3-stage masked Skinny S-box model on the SI/SO side.
// Directed vector table plus hand-written sequences for backpressure, reseed and reset.
module tb_masked_sbox_feeder_d1;

  localparam int          LAT  = 3;
  localparam int          DEPTH = 4;
  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [3:0]  SBOX [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                        4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

  typedef struct {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_s0 = 4'h0;
  logic [3:0]  in_s1 = 4'h0;
  logic        seed_valid = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        seed_ack;
  logic [3:0]  SI_s0, SI_s1, Fresh;
  logic [3:0]  SO_s0, SO_s1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_s0, out_s1;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  got_q[$];
  vec_t        vecs [16];

  logic [3:0]  p0_s0 = 4'h0, p0_s1 = 4'h0, p1_s0 = 4'h0, p1_s1 = 4'h0, p2_s0 = 4'h0, p2_s1 = 4'h0;

  masked_sbox_feeder_d1 #(.LAT(LAT), .DEPTH(DEPTH), .SEED_INIT(SEED)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_s0(in_s0), .in_s1(in_s1),
    .seed_valid(seed_valid), .seed(seed), .seed_ack(seed_ack),
    .SI_s0(SI_s0), .SI_s1(SI_s1), .Fresh(Fresh),
    .SO_s0(SO_s0), .SO_s1(SO_s1),
    .out_valid(out_valid), .out_ready(out_ready), .out_s0(out_s0), .out_s1(out_s1)
  );

  always #5 clk = ~clk;

  // Masked S-box stand-in: three register stages, re-masked with Fresh, never reset.
  always @(posedge clk) begin
    p0_s0 <= SBOX[SI_s0 ^ SI_s1] ^ Fresh;
    p0_s1 <= Fresh;
    p1_s0 <= p0_s0;
    p1_s1 <= p0_s1;
    p2_s0 <= p1_s0;
    p2_s1 <= p1_s1;
  end
  assign SO_s0 = p2_s0;
  assign SO_s1 = p2_s1;

  function automatic logic [31:0] lfsrStep(input logic [31:0] v);
    lfsrStep = {1'b0, v[31:1]} ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous monitor: output capture, SI gating, FIFO-full-at-write and reset outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
    end else begin
      if (out_valid && out_ready) got_q.push_back(out_s0 ^ out_s1);
      if (in_valid && in_ready) begin
        checkOutput("si_issue", {SI_s1, SI_s0}, {in_s1, in_s0});
      end else begin
        checkOutput("si_idle", {SI_s1, SI_s0}, 8'h00);
      end
      if (dut.vld_sr_q[LAT-1]) checkOutput("fifo_not_full_at_write", (dut.count_q == DEPTH), 0);
    end
  end

  task automatic applyStimulus(input logic [3:0] s0, input logic [3:0] s1, output int waits);
    bit done;
    done     = 0;
    waits    = 0;
    in_valid = 1'b1;
    in_s0    = s0;
    in_s1    = s1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else waits++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("issue_timeout", 1, 0);
  endtask

  task automatic waitOutputs(input int n, input int budget);
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("out_count", got_q.size(), n);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w;
    bit          ack_seen;
    logic [31:0] model;

    for (int i = 0; i < 16; i++) begin
      vecs[i].s1  = 4'(i * 7 + 3);
      vecs[i].s0  = 4'(i) ^ vecs[i].s1;
      vecs[i].exp = SBOX[i];
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_seed_ack", seed_ack, 0);
    checkOutput("rst_out_s", {out_s1, out_s0}, 8'h00);
    checkOutput("rst_fresh", Fresh, SEED[3:0]);
    #1 rst_n = 1'b1;

    // LFSR golden sequence while idle
    model = SEED;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      model = lfsrStep(model);
      @(negedge clk);
      checkOutput($sformatf("fresh_%0d", i), Fresh, model[3:0]);
    end
    @(posedge clk);
    #1;

    // Single item with latency check: shares 5/3 unmask to 6
    out_ready = 1'b1;
    applyStimulus(4'h5, 4'h3, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("single_out_valid_%0d", k), out_valid, (k == 3));
      if (k == 3) checkOutput("single_value", out_s0 ^ out_s1, SBOX[6]);
      @(posedge clk);
      #1;
    end
    tick(2);
    got_q.delete();

    // Streaming 16 back-to-back items
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].s0, vecs[i].s1, w);
      checkOutput($sformatf("stream_stall_%0d", i), w, 0);
    end
    waitOutputs(16, 40);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) checkOutput($sformatf("stream_out_%0d", i), got_q[i], vecs[i].exp);
    end
    tick(3);
    got_q.delete();

    // Backpressure: only DEPTH issues with out_ready low
    out_ready = 1'b0;
    begin
      int idx;
      idx      = 0;
      in_valid = 1'b1;
      in_s0    = vecs[4].s0;
      in_s1    = vecs[4].s1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (in_ready) idx++;
        @(posedge clk);
        #1;
        in_s0 = vecs[4 + idx].s0;
        in_s1 = vecs[4 + idx].s1;
      end
      in_valid = 1'b0;
      checkOutput("bp_issues", idx, DEPTH);
    end
    @(negedge clk);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitOutputs(4, 20);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) checkOutput($sformatf("bp_out_%0d", i), got_q[i], vecs[4 + i].exp);
    end
    tick(3);
    got_q.delete();

    // Reseed to zero with two items in flight and a third waiting
    applyStimulus(vecs[10].s0, vecs[10].s1, w);
    applyStimulus(vecs[11].s0, vecs[11].s1, w);
    in_valid   = 1'b1;
    in_s0      = vecs[12].s0;
    in_s1      = vecs[12].s1;
    seed_valid = 1'b1;
    seed       = 32'h0;
    ack_seen   = 0;
    for (int c = 0; c < 12 && !ack_seen; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("reseed_in_ready_drop", in_ready, 0);
      if (seed_ack) begin
        ack_seen = 1;
        checkOutput("reseed_vld_empty", dut.vld_sr_q, 0);
      end
      @(posedge clk);
      #1;
      if (ack_seen) seed_valid = 1'b0;
    end
    checkOutput("reseed_ack_seen", ack_seen, 1);
    @(negedge clk);
    checkOutput("reseed_fresh_1", Fresh, 4'h1);
    checkOutput("reseed_ack_pulse", seed_ack, 0);
    checkOutput("reseed_in_ready_back", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("reseed_fresh_2", Fresh, 4'h3);
    @(posedge clk);
    #1;
    waitOutputs(3, 20);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) checkOutput($sformatf("reseed_out_%0d", i), got_q[i], vecs[10 + i].exp);
    end
    tick(3);
    got_q.delete();

    // Async reset with FIFO holding 3 entries and one still in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(vecs[13 + (i % 3)].s0, vecs[13 + (i % 3)].s1, w);
    tick(2);
    @(negedge clk);
    checkOutput("prereset_out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_reset_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(10);
    checkOutput("no_stale_output", got_q.size(), 0);
    applyStimulus(vecs[3].s0, vecs[3].s1, w);
    waitOutputs(1, 20);
    if (got_q.size() > 0) checkOutput("post_reset_value", got_q[0], vecs[3].exp);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
